// File: rtl/fft_iter_r2.sv
// Iterative radix-2 DIT FFT: loads N real samples in bit-reversed order, runs
// log2(N) in-place stages through one shared butterfly, then streams bins out.
module fft_iter_r2 #(
    parameter int N      = 8,
    parameter int DATA_W = 12,
    parameter int TW_W   = 12,
    parameter int SCALE  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [$clog2(N)-1:0]     out_index,
    output logic                     out_last,
    output logic                     busy
);

    localparam int              LOGN     = $clog2(N);
    localparam int              PW       = DATA_W + TW_W + 1;
    localparam real             PI       = 3.14159265358979323846;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
    localparam logic [LOGN-1:0] LAST_BF  = LOGN'(N / 2 - 1);
    localparam logic [2:0]      LAST_STG = 3'(LOGN - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    function automatic logic signed [TW_W-1:0] tw_round(input real v);
        real sc;
        int  q;
        sc = v * (2.0 ** (TW_W - 2));
        q  = (sc >= 0.0) ? $rtoi(sc + 0.5) : -$rtoi(0.5 - sc);
        return TW_W'(q);
    endfunction

    // Drop the twiddle fraction bits; >>> floors toward -inf.
    function automatic logic signed [DATA_W:0] prod_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        sh = p >>> (TW_W - 2);
        return sh[DATA_W:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] bf_out(input logic signed [DATA_W:0] v);
        if (SCALE != 0) begin
            return v[DATA_W:1];
        end
        return v[DATA_W-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [2:0]      stg_q, stg_d;
    logic            load_we;
    logic            bf_we;

    logic signed [DATA_W-1:0] mem_re [N];
    logic signed [DATA_W-1:0] mem_im [N];

    logic signed [TW_W-1:0] tw_re_rom [N/2];
    logic signed [TW_W-1:0] tw_im_rom [N/2];

    // Twiddle ROM: W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), fixed at elaboration.
    for (genvar g = 0; g < N / 2; g++) begin : g_rom
        assign tw_re_rom[g] = tw_round($cos(2.0 * PI * g / N));
        assign tw_im_rom[g] = tw_round(-$sin(2.0 * PI * g / N));
    end

    // Butterfly address generation
    logic [LOGN-1:0] span;
    logic [LOGN-1:0] span_mask;
    logic [LOGN-1:0] pos;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic [LOGN-2:0] tw_idx;

    always_comb begin
        span      = LOGN'(1) << stg_q;
        span_mask = span - LOGN'(1);
        pos       = j_q & span_mask;
        addr_a    = ((j_q & ~span_mask) << 1) | pos;
        addr_b    = addr_a | span;
        tw_idx    = (LOGN-1)'(pos << (LAST_STG - stg_q));
    end

    // Butterfly datapath: t = W*B, A' = A + t, B' = A - t
    logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW_W-1:0]   w_re, w_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [DATA_W:0]   t_re, t_im;
    logic signed [DATA_W:0]   a_re_x, a_im_x;
    logic signed [DATA_W-1:0] na_re, na_im, nb_re, nb_im;

    always_comb begin
        a_re   = mem_re[addr_a];
        a_im   = mem_im[addr_a];
        b_re   = mem_re[addr_b];
        b_im   = mem_im[addr_b];
        w_re   = tw_re_rom[tw_idx];
        w_im   = tw_im_rom[tw_idx];
        p_rr   = PW'(w_re) * PW'(b_re);
        p_ii   = PW'(w_im) * PW'(b_im);
        p_ri   = PW'(w_re) * PW'(b_im);
        p_ir   = PW'(w_im) * PW'(b_re);
        t_re   = prod_shift(p_rr - p_ii);
        t_im   = prod_shift(p_ri + p_ir);
        a_re_x = (DATA_W+1)'(a_re);
        a_im_x = (DATA_W+1)'(a_im);
        na_re  = bf_out(a_re_x + t_re);
        na_im  = bf_out(a_im_x + t_im);
        nb_re  = bf_out(a_re_x - t_re);
        nb_im  = bf_out(a_im_x - t_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            j_q     <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            stg_q   <= stg_d;
        end
    end

    // cnt_q is the sample index n while loading and the bin index k while
    // unloading; it wraps back to 0 on the last beat of either phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        stg_d   = stg_q;
        load_we = 1'b0;
        bf_we   = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + LOGN'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                bf_we = 1'b1;
                if (j_q == LAST_BF) begin
                    j_d = '0;
                    if (stg_q == LAST_STG) begin
                        stg_d   = '0;
                        state_d = UNLOAD;
                    end else begin
                        stg_d = stg_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + LOGN'(1);
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + LOGN'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Frame memory: data only, never reset
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_re[bitrev(cnt_q)] <= in_data;
            mem_im[bitrev(cnt_q)] <= '0;
        end
        if (bf_we) begin
            mem_re[addr_a] <= na_re;
            mem_im[addr_a] <= na_im;
            mem_re[addr_b] <= nb_re;
            mem_im[addr_b] <= nb_im;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == COMPUTE);
    assign out_valid = (state_q == UNLOAD);
    assign out_re    = out_valid ? mem_re[cnt_q] : '0;
    assign out_im    = out_valid ? mem_im[cnt_q] : '0;
    assign out_index = out_valid ? cnt_q : '0;
    assign out_last  = out_valid && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_fft_iter_r2.sv
// Directed bench for fft_iter_r2: three instances (8-pt scaled, 8-pt unscaled,
// 16-pt 16-bit) driven by hand-computed frames and expected bins.
module tb_fft_iter_r2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [2:0]         in_valid;
    logic [2:0]         out_ready;
    logic signed [15:0] in_data;
    logic [2:0]         in_ready, out_valid, out_last, busy;
    logic signed [11:0] re0, im0, re1, im1;
    logic signed [15:0] re2, im2;
    logic [2:0]         idx0, idx1;
    logic [3:0]         idx2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef int frame_t [16];
    frame_t f, er, ei;

    fft_iter_r2 #(.N(8), .DATA_W(12), .TW_W(12), .SCALE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[11:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_re(re0), .out_im(im0), .out_index(idx0), .out_last(out_last[0]), .busy(busy[0])
    );

    fft_iter_r2 #(.N(8), .DATA_W(12), .TW_W(12), .SCALE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[11:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_re(re1), .out_im(im1), .out_index(idx1), .out_last(out_last[1]), .busy(busy[1])
    );

    fft_iter_r2 #(.N(16), .DATA_W(16), .TW_W(12), .SCALE(1)) u_n16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_re(re2), .out_im(im2), .out_index(idx2), .out_last(out_last[2]), .busy(busy[2])
    );

    function automatic int get_re(input int d);
        if (d == 0) return int'(re0);
        if (d == 1) return int'(re1);
        return int'(re2);
    endfunction

    function automatic int get_im(input int d);
        if (d == 0) return int'(im0);
        if (d == 1) return int'(im1);
        return int'(im2);
    endfunction

    function automatic int get_idx(input int d);
        if (d == 0) return int'(idx0);
        if (d == 1) return int'(idx1);
        return int'(idx2);
    endfunction

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        n_tests++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, int'(in_ready[0]), 1);
        check({tag, "_out_valid"}, int'(out_valid[0]), 0);
        check({tag, "_out_re"}, get_re(0), 0);
        check({tag, "_out_im"}, get_im(0), 0);
        check({tag, "_out_index"}, get_idx(0), 0);
        check({tag, "_out_last"}, int'(out_last[0]), 0);
        check({tag, "_busy"}, int'(busy[0]), 0);
    endtask

    // Called at a falling edge; returns at the falling edge after the last accept.
    task automatic load_frame(input int d, input int n, input bit hold_valid);
        int t;
        for (int i = 0; i < n; i++) begin
            in_data     = 16'(f[i]);
            in_valid[d] = 1'b1;
            t = 0;
            while (!in_ready[d] && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) check("load_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid[d] = hold_valid;
        in_data     = hold_valid ? 16'sd1500 : 16'sd0;
    endtask

    task automatic run_compute(input int d, input int exp_cycles, input string tag);
        int cyc;
        bit rdy_seen;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (busy[d] && cyc < 300) begin
            if (in_ready[d]) rdy_seen = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cyc, exp_cycles);
        check({tag, "_in_ready_compute"}, int'(rdy_seen), 0);
    endtask

    task automatic unload_check(input int d, input int n, input int tol,
                                input int stall_at, input string tag);
        int t;
        out_ready[d] = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (!out_valid[d] && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) check($sformatf("%s_out_timeout_%0d", tag, k), 0, 1);
            if (k == stall_at) begin
                out_ready[d] = 1'b0;
                for (int r = 0; r < 5; r++) begin
                    @(negedge clk);
                    check($sformatf("%s_hold_valid_%0d", tag, r), int'(out_valid[d]), 1);
                    check($sformatf("%s_hold_idx_%0d", tag, r), get_idx(d), k);
                    check($sformatf("%s_hold_re_%0d", tag, r), get_re(d), er[k], tol);
                    check($sformatf("%s_hold_im_%0d", tag, r), get_im(d), ei[k], tol);
                end
                out_ready[d] = 1'b1;
            end
            check($sformatf("%s_idx_%0d", tag, k), get_idx(d), k);
            check($sformatf("%s_re_%0d", tag, k), get_re(d), er[k], tol);
            check($sformatf("%s_im_%0d", tag, k), get_im(d), ei[k], tol);
            check($sformatf("%s_last_%0d", tag, k), int'(out_last[d]), (k == n - 1) ? 1 : 0);
            check($sformatf("%s_in_ready_unload_%0d", tag, k), int'(in_ready[d]), 0);
            @(negedge clk);
        end
        check({tag, "_valid_after"}, int'(out_valid[d]), 0);
        check({tag, "_reload_ready"}, int'(in_ready[d]), 1);
    endtask

    task automatic set_impulse(input int amp, input int bin_val);
        for (int i = 0; i < 16; i++) begin
            f[i]  = 0;
            er[i] = bin_val;
            ei[i] = 0;
        end
        f[0] = amp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        #3;
        check_reset("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Impulse, scaled: 1000/8 = 125 in every bin
        set_impulse(1000, 125);
        load_frame(0, 8, 1'b0);
        run_compute(0, 12, "imp");
        unload_check(0, 8, 0, -1, "imp");

        // Impulse, unscaled
        set_impulse(1000, 1000);
        load_frame(1, 8, 1'b0);
        run_compute(1, 12, "imp_ns");
        unload_check(1, 8, 0, -1, "imp_ns");

        // DC frame
        for (int i = 0; i < 16; i++) begin
            f[i] = 800; er[i] = 0; ei[i] = 0;
        end
        er[0] = 800;
        load_frame(0, 8, 1'b0);
        run_compute(0, 12, "dc");
        unload_check(0, 8, 0, -1, "dc");

        // Alternating +/-400: all energy at Nyquist
        for (int i = 0; i < 16; i++) begin
            f[i] = (i % 2 == 0) ? 400 : -400; er[i] = 0; ei[i] = 0;
        end
        er[4] = 400;
        load_frame(0, 8, 1'b0);
        run_compute(0, 12, "alt");
        unload_check(0, 8, 0, -1, "alt");

        // One cycle of cosine: bins 1 and 7 at 1024/2
        f[0] = 1024; f[1] = 724;  f[2] = 0; f[3] = -724;
        f[4] = -1024; f[5] = -724; f[6] = 0; f[7] = 724;
        for (int i = 0; i < 16; i++) begin
            er[i] = 0; ei[i] = 0;
        end
        er[1] = 512;
        er[7] = 512;
        load_frame(0, 8, 1'b0);
        run_compute(0, 12, "cos");
        unload_check(0, 8, 2, -1, "cos");

        // Backpressure at bin 3 with stray in_valid during COMPUTE/UNLOAD
        set_impulse(1000, 125);
        load_frame(0, 8, 1'b1);
        run_compute(0, 12, "bp");
        unload_check(0, 8, 0, 3, "bp");
        in_valid[0] = 1'b0;
        in_data     = '0;

        // Asynchronous reset in the middle of COMPUTE
        set_impulse(1000, 125);
        load_frame(0, 8, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_busy_before_rst", int'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rel_in_ready", int'(in_ready[0]), 1);
        load_frame(0, 8, 1'b0);
        run_compute(0, 12, "post_rst");
        unload_check(0, 8, 0, -1, "post_rst");

        // Back-to-back 16-point frames: 4096/16 = 256
        set_impulse(4096, 256);
        load_frame(2, 16, 1'b0);
        run_compute(2, 32, "n16_a");
        unload_check(2, 16, 0, -1, "n16_a");
        load_frame(2, 16, 1'b0);
        run_compute(2, 32, "n16_b");
        unload_check(2, 16, 0, -1, "n16_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_iter_r2.md
Name: fft_iter_r2

Overview:
- Parametrised, iterative radix-2 decimation-in-time FFT. It is the successor to the fixed 8-point, 12-bit, fully unrolled butterfly network.
- Accepts one real sample per handshake and stores a frame in an internal register array.
- Runs log2(N) stages in place through a single time-shared butterfly, then streams complex bins out in natural order with backpressure.
- Sits between the audio framing logic and the feature-extraction stage of the speech front end.

Parameters:
- N, 8, points per frame; power of two, 4..64.
- DATA_W, 12, signed width of input samples, memory words and outputs.
- TW_W, 12, signed twiddle width. Twiddle value 1.0 = 2^(TW_W-2).
- SCALE, 1, 1 = arithmetic shift right by 1 after every stage (result = DFT/N); 0 = no scaling, results wrap to DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  signed real sample, frame order n=0..N-1.
- out_valid  out  1  out_re/out_im/out_index valid.
- out_ready  in  1  downstream accepts the bin this cycle.
- out_re  out  DATA_W  signed real part of bin.
- out_im  out  DATA_W  signed imaginary part of bin.
- out_index  out  log2(N)  bin number k.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE.

Behaviour:
- Clock, reset: one clock (clk); rst_n asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_re=out_im=0, out_index=0, out_last=0, busy=0, FSM=LOAD, all counters 0. Array contents are not reset.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready writes the real part = in_data and the imaginary part = 0 at address bitrev(n).
  - After the N-th accepted sample, go to COMPUTE next cycle with in_ready=0.
- COMPUTE:
  - One butterfly per cycle; stage s=0..log2(N)-1, butterfly j=0..N/2-1. Exactly (N/2)*log2(N) cycles (N=8: 12 cycles).
  - span=2^s, grp=j/span, pos=j mod span. Operand addresses: a=grp*2*span+pos, b=a+span. Twiddle index k=pos*(N/(2*span)).
  - Twiddle W=cos(2pi k/N)-j*sin(2pi k/N), held in a ROM of N/2 entries computed at elaboration and rounded to nearest.
  - t = W*B. Each product is sign-extended to full width, summed, then arithmetic-shifted right by TW_W-2 (truncation toward -inf).
  - A' = A+t, B' = A-t, computed at DATA_W+1 bits. Then shift right 1 if SCALE=1, and keep the low DATA_W bits.
  - Combinational read and registered write in the same cycle.
  - in_valid is ignored (in_ready=0).
- UNLOAD:
  - Present bins k=0..N-1 from address k. out_valid=1 and outputs stay stable while out_ready=0.
  - On out_valid&&out_ready, advance k. out_last=1 exactly when out_index=N-1.
  - After the last handshake, out_valid=0 and go to LOAD with in_ready=1 the next cycle.
  - in_ready=0 throughout UNLOAD.
- Simultaneous events: in_valid and out_ready are each ignored outside their state; there is no overlap of frames.
- Reset mid-operation: an asserted rst_n immediately forces the reset values. The partial frame is discarded. The first frame after release is computed correctly.
- Throughput per frame: N load cycles + (N/2)log2N compute cycles + N unload cycles, with zero added latency between states when handshakes are continuous.

Test Plan:
- Impulse: N=8, SCALE=1, frame {1000,0,0,0,0,0,0,0} -> all 8 bins re=125, im=0; out_last only on index 7; busy high exactly 12 cycles.
- Same impulse with SCALE=0 -> all bins re=1000, im=0. DC frame of eight 800s with SCALE=1 -> bin0 re=800, all other bins 0,0.
- Alternating {+400,-400,...}, SCALE=1 -> bin4 re=400, all others 0. Cosine 1024*cos(2pi n/8) rounded -> bins 1 and 7 re=512+/-2, im within +/-2; others within +/-2.
- Backpressure: out_ready low for 5 cycles at bin 3 -> out_re/out_im/out_index held at bin 3. Then the remaining bins arrive in order with no loss or duplication. in_valid pulses during COMPUTE/UNLOAD are not accepted.
- Reset mid-COMPUTE (after cycle 6): outputs take reset values asynchronously and in_ready=1 after release. Next impulse frame yields 125 in all bins.
- Back-to-back frames with continuous in_valid/out_ready, N=16, DATA_W=16 -> second frame's in_ready rises one cycle after first frame's out_last handshake. Impulse 4096 gives 256 in all 16 bins.
